// File: rtl/expr_eval.sv
// Evaluates single-digit '+'/'*' ASCII expressions with '*' before '+'; flags malformed input.
// Latency: the '=' sampled at an edge shows result/done after that edge; no bubble before the next expression.
// Backpressure: none; one character per cycle when in_valid is high, and in_valid low holds all state.
module expr_eval (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  in,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    FIRST = 3'd0,
    OP    = 3'd1,
    DIG   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [7:0] CH_PLUS = 8'h2b;
  localparam logic [7:0] CH_STAR = 8'h2a;
  localparam logic [7:0] CH_EQ   = 8'h3d;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  state_t      state, state_nxt;
  logic [31:0] sum, sum_nxt;
  logic [31:0] term, term_nxt;
  logic        last_mul, last_mul_nxt;   // 1: last operator was '*', 0: '+'
  logic [31:0] result_nxt;

  logic        is_dig;
  logic [31:0] dval;
  logic [31:0] prod;

  // ASCII '0'..'9' carry their value in the low nibble.
  assign is_dig = (in >= CH_0) && (in <= CH_9);
  assign dval   = {28'd0, in[3:0]};
  assign prod   = term * dval;

  // Flags decode straight from the registered state so reset clears them at once.
  assign done = (state == DONE);
  assign err  = (state == ERR);

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= FIRST;
      sum      <= 32'd0;
      term     <= 32'd0;
      last_mul <= 1'b0;
      result   <= 32'd0;
    end else begin
      state    <= state_nxt;
      sum      <= sum_nxt;
      term     <= term_nxt;
      last_mul <= last_mul_nxt;
      result   <= result_nxt;
    end
  end

  // Next-state and datapath update for each accepted character.
  always_comb begin
    state_nxt    = state;
    sum_nxt      = sum;
    term_nxt     = term;
    last_mul_nxt = last_mul;
    result_nxt   = result;
    if (in_valid) begin
      case (state)
        FIRST, DONE: begin
          if (is_dig) begin
            sum_nxt   = 32'd0;
            term_nxt  = dval;
            state_nxt = OP;
          end else begin
            state_nxt = ERR;
          end
        end
        OP: begin
          if (in == CH_PLUS || in == CH_STAR) begin
            last_mul_nxt = (in == CH_STAR);
            state_nxt    = DIG;
          end else if (in == CH_EQ) begin
            result_nxt = sum + term;
            state_nxt  = DONE;
          end else begin
            state_nxt = ERR;
          end
        end
        DIG: begin
          if (is_dig) begin
            if (last_mul) begin
              term_nxt = prod;
            end else begin
              sum_nxt  = sum + term;
              term_nxt = dval;
            end
            state_nxt = OP;
          end else begin
            state_nxt = ERR;
          end
        end
        ERR: begin
          if (in == CH_EQ) state_nxt = FIRST;
        end
        default: state_nxt = FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: expected results queued when '=' is driven, popped when done is expected.
// Outputs are sampled 1 time unit after each rising edge.
// Gaps drive a stray digit with in_valid low to confirm it is ignored.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  in;
  logic        in_valid;
  logic [31:0] result;
  logic        done;
  logic        err;

  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_res = 32'd0;

  expr_eval dut (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .result   (result),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Flag character: '.' idle/busy, 'D' done, 'E' error.
  task automatic check_outs(input string tag, input byte f, input bit pop);
    if (pop && f == "D") begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $error("FAIL %s: observed empty scoreboard expected a queued result", tag);
      end else begin
        exp_res = sb.pop_front();
      end
    end
    chk({tag, ".done"},   32'(done),  32'(f == "D"));
    chk({tag, ".err"},    32'(err),   32'(f == "E"));
    chk({tag, ".result"}, result,     exp_res);
  endtask

  task automatic feed(input string s, input string f, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      in       = s[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_outs($sformatf("%s[%0d]", s, i), f[i], 1'b1);
      for (int g = 0; g < gap; g++) begin
        in = "1";
        @(posedge clk);
        #1;
        check_outs($sformatf("%s[%0d].gap%0d", s, i, g), f[i], 1'b0);
      end
    end
  endtask

  // Well-formed expression: busy on every character, done on the final '='.
  task automatic feed_ok(input string s, input int gap, input logic [31:0] val);
    string f;
    f = "";
    for (int i = 0; i < s.len() - 1; i++) f = {f, "."};
    f = {f, "D"};
    sb.push_back(val);
    feed(s, f, gap);
  endtask

  task automatic pulse_clr(input string tag);
    #2;
    clr = 1'b0;
    #1;
    exp_res = 32'd0;
    sb.delete();
    check_outs(tag, ".", 1'b0);
    #3;
    clr = 1'b1;
  endtask

  initial begin
    clr      = 1'b0;
    in       = 8'h00;
    in_valid = 1'b0;
    #1;
    check_outs("reset", ".", 1'b0);
    #12;
    clr = 1'b1;

    feed_ok("1+2*3=", 0, 32'd7);
    feed_ok("9*9*9*9*9*9*9*9*9*9*9=", 0, 32'd1316288537);
    feed_ok("2*3+4*5+6=", 2, 32'd32);

    // Double operator: error, '=' resyncs to FIRST, result held.
    feed("1++2=", "..EE.", 0);
    feed_ok("4*5+6=", 0, 32'd26);

    // Illegal codes from OP and FIRST, '=' straight out of DONE.
    feed("1a=", ".E.", 0);
    feed("x=", "E.", 0);
    feed_ok("9=", 0, 32'd9);
    feed("==", "E.", 0);

    // Asynchronous clear mid-expression, then in ERR.
    feed_ok("2+2=", 0, 32'd4);
    feed("5*6+", "....", 0);
    pulse_clr("clr_mid_expr");
    feed("+", "E", 0);
    pulse_clr("clr_in_err");
    feed_ok("8=", 0, 32'd8);

    // Back-to-back expressions with no bubble; zero product.
    feed_ok("7=", 0, 32'd7);
    feed_ok("3*0=", 0, 32'd0);
    feed_ok("0+0*9+1=", 1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
